single_cycle_main: RTL and testbench

// - Top level of the single-cycle 32-bit MIPS-subset processor: PC, instruction memory, register file, ALU, data memory, control.
// - Every instruction fetches, decodes, executes and writes back in one clk cycle. The only ports are clock and reset.
// - Benches load programs and observe state hierarchically. Instance names: asset_pc (reg pc_out[31:0]),

---
 rtl/single_cycle_main.sv | 209 ++++++++++++++++++++
 tb/tb_single_cycle_main.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/single_cycle_main.sv
// Single-cycle 32-bit MIPS-subset processor: PC, instruction memory, register
// file, ALU, data memory and decode, all completing one instruction per clk.
// Optional feature macro: JAL_EN (adds jal and jr).

// Program counter register; reset to 0.
module sc_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc_next,
  output logic [31:0] o_pc
);
  logic [31:0] pc_out;

  // PC latches the selected next address every edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values of the others.
    if (rst) pc_out <= '0;
    else     pc_out <= i_pc_next;
  end

  assign o_pc = pc_out;
endmodule

// Instruction memory; loaded externally, out-of-range fetch returns 0 (nop).
module sc_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [29:0]   i_word_idx,
  output logic [31:0]   o_instr
);
  logic [31:0] mem [0:DEPTH-1];

  // Optional load port; program contents survive reset.
  always_ff @(posedge clk) begin
    // NOTE: program storage has no reset; reset clears architectural state,
    // never the program image.
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_instr = (i_word_idx < 30'(DEPTH)) ? mem[i_word_idx[AW-1:0]] : 32'h0;
endmodule

// Register file: two combinational reads, one clocked write, $0 hardwired.
module sc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] RegData [0:31];

  // Clear all registers on reset; drop writes aimed at $0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) RegData[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      RegData[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = RegData[i_raddr_a];
  assign o_rdata_b = RegData[i_raddr_b];
endmodule

// Data memory: combinational read, clocked write, cleared on reset.
// DEPTH is a power of two so the index wraps by truncation.
module sc_dmem #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] mem [0:DEPTH-1];

  // Store word on sw; whole array zeroed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_we) begin
      mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_idx];
endmodule

module single_cycle_main #(
  parameter int IM_DEPTH = 64,
  parameter int DM_DEPTH = 32
) (
  input  logic clk,
  input  logic rst
);
  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  logic [31:0] w_pc, w_pc_plus4, w_pc_next, w_instr;
  logic [31:0] w_rs_data, w_rt_data, w_imm_ext, w_alu_b, w_alu_y;
  logic [31:0] w_dm_rdata, w_wb_data, w_branch_tgt, w_jump_tgt;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
  logic        w_reg_we, w_alu_imm, w_zext, w_mem_we, w_mem_to_reg;
  logic        w_beq, w_bne, w_jump, w_link, w_jr, w_taken;
  alu_op_e     w_alu_op;
  logic        w_unused_bits;

  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_funct = w_instr[5:0];
  assign w_unused_bits = ^w_instr[10:6];

  sc_pc asset_pc (.clk(clk), .rst(rst), .i_pc_next(w_pc_next), .o_pc(w_pc));

  sc_imem #(.DEPTH(IM_DEPTH)) asset_im (
    .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wdata('0),
    .i_word_idx(w_pc[31:2]), .o_instr(w_instr)
  );

  sc_regfile asset_reg (
    .clk(clk), .rst(rst), .i_we(w_reg_we), .i_waddr(w_waddr), .i_wdata(w_wb_data),
    .i_raddr_a(w_rs), .i_raddr_b(w_rt), .o_rdata_a(w_rs_data), .o_rdata_b(w_rt_data)
  );

  sc_dmem #(.DEPTH(DM_DEPTH)) asset_dm (
    .clk(clk), .rst(rst), .i_we(w_mem_we), .i_idx(w_alu_y[DAW+1:2]),
    .i_wdata(w_rt_data), .o_rdata(w_dm_rdata)
  );

  // Decode: unknown opcodes/functs fall through to the all-zero nop defaults.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_reg_we = 1'b0; w_waddr = w_rt; w_alu_imm = 1'b0; w_zext = 1'b0;
    w_mem_we = 1'b0; w_mem_to_reg = 1'b0; w_beq = 1'b0; w_bne = 1'b0;
    w_jump = 1'b0; w_link = 1'b0; w_jr = 1'b0; w_alu_op = ALU_ADD;
    case (w_op)
      6'h00: begin
        w_waddr = w_rd;
        case (w_funct)
          6'h20: begin w_reg_we = 1'b1; w_alu_op = ALU_ADD; end
          6'h22: begin w_reg_we = 1'b1; w_alu_op = ALU_SUB; end
          6'h24: begin w_reg_we = 1'b1; w_alu_op = ALU_AND; end
          6'h25: begin w_reg_we = 1'b1; w_alu_op = ALU_OR;  end
          6'h2A: begin w_reg_we = 1'b1; w_alu_op = ALU_SLT; end
`ifdef JAL_EN
          6'h08: w_jr = 1'b1;
`endif
          default: ;
        endcase
      end
      6'h08: begin w_reg_we = 1'b1; w_alu_imm = 1'b1; end
      6'h0C: begin w_reg_we = 1'b1; w_alu_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_AND; end
      6'h23: begin w_reg_we = 1'b1; w_alu_imm = 1'b1; w_mem_to_reg = 1'b1; end
      6'h2B: begin w_mem_we = 1'b1; w_alu_imm = 1'b1; end
      6'h04: w_beq = 1'b1;
      6'h05: w_bne = 1'b1;
      6'h02: w_jump = 1'b1;
`ifdef JAL_EN
      6'h03: begin w_jump = 1'b1; w_link = 1'b1; w_reg_we = 1'b1; w_waddr = 5'd31; end
`endif
      default: ;
    endcase
  end

  assign w_imm_ext = w_zext ? {16'h0, w_instr[15:0]} : {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_alu_b   = w_alu_imm ? w_imm_ext : w_rt_data;

  // ALU: wrapping two's complement arithmetic, signed set-less-than.
  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_y = w_rs_data + w_alu_b;
      ALU_SUB: w_alu_y = w_rs_data - w_alu_b;
      ALU_AND: w_alu_y = w_rs_data & w_alu_b;
      ALU_OR:  w_alu_y = w_rs_data | w_alu_b;
      ALU_SLT: w_alu_y = {31'h0, $signed(w_rs_data) < $signed(w_alu_b)};
      default: w_alu_y = '0;
    endcase
  end

  assign w_pc_plus4   = w_pc + 32'd4;
  assign w_branch_tgt = w_pc_plus4 + {w_imm_ext[29:0], 2'b00};
  assign w_jump_tgt   = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
  assign w_taken      = (w_beq && (w_rs_data == w_rt_data)) ||
                        (w_bne && (w_rs_data != w_rt_data));
  assign w_wb_data    = w_link ? w_pc_plus4 : (w_mem_to_reg ? w_dm_rdata : w_alu_y);
  assign w_pc_next    = w_jr ? w_rs_data : w_jump ? w_jump_tgt :
                        w_taken ? w_branch_tgt : w_pc_plus4;
endmodule

// File: tb/tb_single_cycle_main.sv
// Directed bench for single_cycle_main: loads programs hierarchically and
// checks PC, registers and data memory after each executing edge.
module tb_single_cycle_main;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  single_cycle_main dut (.clk(clk), .rst(rst));

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_im();
    for (int i = 0; i < 64; i++) dut.asset_im.mem[i] = 32'h0;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 32; i++) dut.asset_reg.RegData[i] = 32'hFFFF_FFFF;
    #1 rst = 1'b1;
    #1;
    checks++; if (dut.asset_pc.pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h0); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (dut.asset_reg.RegData[i] !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, dut.asset_reg.RegData[i], 32'h0); end
    end
    clear_im();
    dut.asset_im.mem[0]  = 32'h2010_0005; // addi $s0,$0,5
    dut.asset_im.mem[1]  = 32'h2011_FFFD; // addi $s1,$0,-3
    dut.asset_im.mem[2]  = 32'h0230_402A; // slt $t0,$s1,$s0
    dut.asset_im.mem[3]  = 32'h0211_4822; // sub $t1,$s0,$s1
    dut.asset_im.mem[4]  = 32'h1210_0002; // beq $s0,$s0,+2
    dut.asset_im.mem[7]  = 32'h0211_5024; // and $t2,$s0,$s1
    dut.asset_im.mem[8]  = 32'h322B_FFFF; // andi $t3,$s1,0xFFFF
    dut.asset_im.mem[9]  = 32'hAC10_0004; // sw $s0,4($0)
    dut.asset_im.mem[10] = 32'h8C0C_0004; // lw $t4,4($0)
    dut.asset_im.mem[11] = 32'h8C0D_0008; // lw $t5,8($0)
    dut.asset_im.mem[12] = 32'h1610_0002; // bne $s0,$s0,+2
    dut.asset_im.mem[13] = 32'h2000_0007; // addi $0,$0,7
    dut.asset_im.mem[14] = 32'hFC00_0000; // undefined op 3F
    dut.asset_im.mem[15] = 32'h0800_0000; // j 0
    #2 rst = 1'b0;
  endtask

  task automatic test_immediates();
    step(); step();
    checks++; if (dut.asset_reg.RegData[16] !== 32'h5) begin failures++; $display("FAIL addi_s0 got=%h exp=%h", dut.asset_reg.RegData[16], 32'h5); end
    checks++; if (dut.asset_reg.RegData[17] !== 32'hFFFF_FFFD) begin failures++; $display("FAIL addi_s1 got=%h exp=%h", dut.asset_reg.RegData[17], 32'hFFFF_FFFD); end
    checks++; if (dut.asset_pc.pc_out !== 32'h8) begin failures++; $display("FAIL pc_after_imm got=%h exp=%h", dut.asset_pc.pc_out, 32'h8); end
  endtask

  task automatic test_alu();
    step();
    checks++; if (dut.asset_reg.RegData[8] !== 32'h1) begin failures++; $display("FAIL slt got=%h exp=%h", dut.asset_reg.RegData[8], 32'h1); end
    step();
    checks++; if (dut.asset_reg.RegData[9] !== 32'h8) begin failures++; $display("FAIL sub got=%h exp=%h", dut.asset_reg.RegData[9], 32'h8); end
    checks++; if (dut.asset_pc.pc_out !== 32'h10) begin failures++; $display("FAIL pc_before_beq got=%h exp=%h", dut.asset_pc.pc_out, 32'h10); end
  endtask

  task automatic test_branch_logic();
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h1C) begin failures++; $display("FAIL beq_taken got=%h exp=%h", dut.asset_pc.pc_out, 32'h1C); end
    step();
    checks++; if (dut.asset_reg.RegData[10] !== 32'h5) begin failures++; $display("FAIL and got=%h exp=%h", dut.asset_reg.RegData[10], 32'h5); end
    step();
    checks++; if (dut.asset_reg.RegData[11] !== 32'h0000_FFFD) begin failures++; $display("FAIL andi got=%h exp=%h", dut.asset_reg.RegData[11], 32'h0000_FFFD); end
    checks++; if (dut.asset_pc.pc_out !== 32'h24) begin failures++; $display("FAIL pc_after_andi got=%h exp=%h", dut.asset_pc.pc_out, 32'h24); end
  endtask

  task automatic test_memory();
    step();
    checks++; if (dut.asset_dm.mem[1] !== 32'h5) begin failures++; $display("FAIL sw_word got=%h exp=%h", dut.asset_dm.mem[1], 32'h5); end
    step();
    checks++; if (dut.asset_reg.RegData[12] !== 32'h5) begin failures++; $display("FAIL lw got=%h exp=%h", dut.asset_reg.RegData[12], 32'h5); end
    dut.asset_reg.RegData[13] = 32'hDEAD_BEEF;
    step();
    checks++; if (dut.asset_reg.RegData[13] !== 32'h0) begin failures++; $display("FAIL lw_unwritten got=%h exp=%h", dut.asset_reg.RegData[13], 32'h0); end
  endtask

  task automatic test_control_edges();
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h34) begin failures++; $display("FAIL bne_not_taken got=%h exp=%h", dut.asset_pc.pc_out, 32'h34); end
    step();
    checks++; if (dut.asset_reg.RegData[0] !== 32'h0) begin failures++; $display("FAIL reg0_write got=%h exp=%h", dut.asset_reg.RegData[0], 32'h0); end
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h3C) begin failures++; $display("FAIL undef_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h3C); end
    checks++; if (dut.asset_dm.mem[1] !== 32'h5) begin failures++; $display("FAIL undef_mem got=%h exp=%h", dut.asset_dm.mem[1], 32'h5); end
    checks++; if (dut.asset_reg.RegData[8] !== 32'h1) begin failures++; $display("FAIL undef_reg got=%h exp=%h", dut.asset_reg.RegData[8], 32'h1); end
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h0) begin failures++; $display("FAIL jump_zero got=%h exp=%h", dut.asset_pc.pc_out, 32'h0); end
  endtask

  task automatic test_fetch_range();
    dut.asset_im.mem[1] = 32'h0800_0040; // j 0x100 (word index 64, out of range)
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h4) begin failures++; $display("FAIL rerun_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h4); end
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h100) begin failures++; $display("FAIL jump_far got=%h exp=%h", dut.asset_pc.pc_out, 32'h100); end
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h104) begin failures++; $display("FAIL oob_nop_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h104); end
    checks++; if (dut.asset_reg.RegData[17] !== 32'hFFFF_FFFD) begin failures++; $display("FAIL oob_nop_reg got=%h exp=%h", dut.asset_reg.RegData[17], 32'hFFFF_FFFD); end
  endtask

  task automatic test_reset_mid();
    #5 rst = 1'b1;
    #1;
    checks++; if (dut.asset_pc.pc_out !== 32'h0) begin failures++; $display("FAIL mid_reset_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h0); end
    checks++; if (dut.asset_reg.RegData[16] !== 32'h0) begin failures++; $display("FAIL mid_reset_reg got=%h exp=%h", dut.asset_reg.RegData[16], 32'h0); end
    checks++; if (dut.asset_dm.mem[1] !== 32'h0) begin failures++; $display("FAIL mid_reset_mem got=%h exp=%h", dut.asset_dm.mem[1], 32'h0); end
    clear_im();
    dut.asset_im.mem[0]  = 32'h2010_0009; // addi $s0,$0,9
    dut.asset_im.mem[8]  = 32'h0C00_000C; // jal 0x30
    dut.asset_im.mem[12] = 32'h03E0_0008; // jr $ra
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h0) begin failures++; $display("FAIL held_in_reset got=%h exp=%h", dut.asset_pc.pc_out, 32'h0); end
    #4 rst = 1'b0;
    step();
    checks++; if (dut.asset_reg.RegData[16] !== 32'h9) begin failures++; $display("FAIL restart_exec got=%h exp=%h", dut.asset_reg.RegData[16], 32'h9); end
    checks++; if (dut.asset_pc.pc_out !== 32'h4) begin failures++; $display("FAIL restart_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h4); end
  endtask

  task automatic test_jal();
    for (int i = 0; i < 7; i++) step();
    checks++; if (dut.asset_pc.pc_out !== 32'h20) begin failures++; $display("FAIL pc_at_jal got=%h exp=%h", dut.asset_pc.pc_out, 32'h20); end
    step();
`ifdef JAL_EN
    checks++; if (dut.asset_reg.RegData[31] !== 32'h24) begin failures++; $display("FAIL jal_ra got=%h exp=%h", dut.asset_reg.RegData[31], 32'h24); end
    checks++; if (dut.asset_pc.pc_out !== 32'h30) begin failures++; $display("FAIL jal_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h30); end
    step();
    checks++; if (dut.asset_pc.pc_out !== 32'h24) begin failures++; $display("FAIL jr_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h24); end
`else
    checks++; if (dut.asset_reg.RegData[31] !== 32'h0) begin failures++; $display("FAIL jal_nop_ra got=%h exp=%h", dut.asset_reg.RegData[31], 32'h0); end
    checks++; if (dut.asset_pc.pc_out !== 32'h24) begin failures++; $display("FAIL jal_nop_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h24); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (dut.asset_pc.pc_out !== 32'h34) begin failures++; $display("FAIL jr_nop_pc got=%h exp=%h", dut.asset_pc.pc_out, 32'h34); end
`endif
  endtask

  initial begin
    test_reset();
    test_immediates();
    test_alu();
    test_branch_logic();
    test_memory();
    test_control_edges();
    test_fetch_range();
    test_reset_mid();
    test_jal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
